// File: rtl/echo_codificador_serial.sv
// Packs N_DIG BCD digits into Johnson display codes and emits them one per cycle.
// Output is registered (1 cycle after accept); HOLD freezes everything; RDY reopens on the last digit.
module echo_codificador_serial #(
  parameter int N_DIG        = 4,
  parameter bit MSD_FIRST    = 1'b1,
  parameter bit WRAP_INVALID = 1'b1,
  parameter int IDX_W        = (N_DIG > 1) ? $clog2(N_DIG) : 1
) (
  input  logic               CLK,
  input  logic               RS,
  input  logic               RE,
  input  logic [4*N_DIG-1:0] D_IN,
  input  logic               HOLD,
  output logic               RDY,
  output logic [4:0]         S_OUT,
  output logic               S_VLD,
  output logic               S_LAST,
  output logic [IDX_W-1:0]   S_IDX,
  output logic               ERR
);

  localparam logic [IDX_W-1:0] FIRST_IDX = MSD_FIRST ? IDX_W'(N_DIG - 1) : '0;
  localparam logic [IDX_W-1:0] LAST_IDX  = MSD_FIRST ? '0 : IDX_W'(N_DIG - 1);
  localparam bit               ONE_DIGIT = (N_DIG == 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state, state_n;
  logic [4*N_DIG-1:0] word, word_n;
  logic [IDX_W-1:0]   idx_n, idx_step;
  logic [4:0]         out_n;
  logic               last_n, err_n, accept;
  logic [5:0]         enc_new, enc_adv;

  function automatic logic [4:0] johnson(input logic [3:0] v);
    case (v)
      4'd0:    johnson = 5'b11111;
      4'd1:    johnson = 5'b01111;
      4'd2:    johnson = 5'b00111;
      4'd3:    johnson = 5'b00011;
      4'd4:    johnson = 5'b00001;
      4'd6:    johnson = 5'b10000;
      4'd7:    johnson = 5'b11000;
      4'd8:    johnson = 5'b11100;
      4'd9:    johnson = 5'b11110;
      default: johnson = 5'b00000;
    endcase
  endfunction

  // Returns {err, code}; out-of-range digits either wrap or show an illegal pattern.
  function automatic logic [5:0] encode(input logic [3:0] d);
    if (d > 4'd9)
      encode = WRAP_INVALID ? {1'b1, johnson(d - 4'd10)} : {1'b1, 5'b10101};
    else
      encode = {1'b0, johnson(d)};
  endfunction

  assign S_VLD    = (state == SHIFT);
  assign RDY      = ~RS & ((state == IDLE) | (S_VLD & S_LAST & ~HOLD));
  assign accept   = RE & RDY;
  assign idx_step = MSD_FIRST ? (S_IDX - IDX_W'(1)) : (S_IDX + IDX_W'(1));
  assign enc_new  = encode(D_IN[4*int'(FIRST_IDX) +: 4]);
  assign enc_adv  = encode(word[4*int'(idx_step) +: 4]);

  always_comb begin
    state_n = state;
    word_n  = word;
    idx_n   = S_IDX;
    out_n   = S_OUT;
    last_n  = S_LAST;
    err_n   = ERR;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n = SHIFT;
          word_n  = D_IN;
          idx_n   = FIRST_IDX;
          {err_n, out_n} = enc_new;
          last_n  = ONE_DIGIT;
        end
      end
      SHIFT: begin
        if (!HOLD) begin
          if (!S_LAST) begin
            idx_n  = idx_step;
            {err_n, out_n} = enc_adv;
            last_n = (idx_step == LAST_IDX);
          end else if (accept) begin
            // Back-to-back word: load without an idle bubble.
            word_n = D_IN;
            idx_n  = FIRST_IDX;
            {err_n, out_n} = enc_new;
            last_n = ONE_DIGIT;
          end else begin
            state_n = IDLE;
            idx_n   = '0;
            out_n   = 5'b00000;
            last_n  = 1'b0;
            err_n   = 1'b0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RS) begin
      state  <= IDLE;
      word   <= '0;
      S_IDX  <= '0;
      S_OUT  <= 5'b00000;
      S_LAST <= 1'b0;
      ERR    <= 1'b0;
    end else begin
      state  <= state_n;
      word   <= word_n;
      S_IDX  <= idx_n;
      S_OUT  <= out_n;
      S_LAST <= last_n;
      ERR    <= err_n;
    end
  end

endmodule

// File: tb/tb_echo_codificador_serial.sv
// Scoreboard bench: two instances (wrap and no-wrap) share stimulus; expected digits are queued on accept.
module tb_echo_codificador_serial;

  typedef struct packed {
    logic [4:0] code;
    logic [1:0] idx;
    logic       last;
    logic       err;
  } exp_t;

  logic        clk, rs, re, hold;
  logic [15:0] d_in;
  logic        rdy_a, vld_a, last_a, err_a;
  logic        rdy_b, vld_b, last_b, err_b;
  logic [4:0]  out_a, out_b;
  logic [1:0]  idx_a, idx_b;

  exp_t qa[$];
  exp_t qb[$];
  int   n_tests, n_fail, vcnt, vraw, v0, r0;
  logic mon_en;

  logic [4:0] jt [0:9] = '{5'b11111, 5'b01111, 5'b00111, 5'b00011, 5'b00001,
                           5'b00000, 5'b10000, 5'b11000, 5'b11100, 5'b11110};

  echo_codificador_serial #(.N_DIG(4), .MSD_FIRST(1'b1), .WRAP_INVALID(1'b1)) dut_a (
    .CLK(clk), .RS(rs), .RE(re), .D_IN(d_in), .HOLD(hold), .RDY(rdy_a),
    .S_OUT(out_a), .S_VLD(vld_a), .S_LAST(last_a), .S_IDX(idx_a), .ERR(err_a));

  echo_codificador_serial #(.N_DIG(4), .MSD_FIRST(1'b1), .WRAP_INVALID(1'b0)) dut_b (
    .CLK(clk), .RS(rs), .RE(re), .D_IN(d_in), .HOLD(hold), .RDY(rdy_b),
    .S_OUT(out_b), .S_VLD(vld_b), .S_LAST(last_b), .S_IDX(idx_b), .ERR(err_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void push(input logic [15:0] w);
    for (int k = 3; k >= 0; k--) begin
      logic [3:0] dg;
      exp_t ea, eb;
      dg = w[4*k +: 4];
      ea.code = (dg > 4'd9) ? jt[dg - 4'd10] : jt[dg];
      eb.code = (dg > 4'd9) ? 5'b10101 : jt[dg];
      ea.idx  = 2'(k);
      ea.last = (k == 0);
      ea.err  = (dg > 4'd9);
      eb.idx  = ea.idx;
      eb.last = ea.last;
      eb.err  = ea.err;
      qa.push_back(ea);
      qb.push_back(eb);
    end
  endfunction

  // Peek while held, pop only on edges that will advance.
  always @(negedge clk) begin
    if (mon_en && !rs) begin
      if (vld_a) begin
        vraw++;
        if (qa.size() == 0) check("a_vld_unexpected", vld_a, 1'b0);
        else begin
          check("a_code", out_a, qa[0].code);
          check("a_idx",  idx_a, qa[0].idx);
          check("a_last", last_a, qa[0].last);
          check("a_err",  err_a, qa[0].err);
          if (!hold) begin
            void'(qa.pop_front());
            vcnt++;
          end
        end
      end else begin
        check("a_idle_out", {err_a, last_a, out_a}, 7'd0);
      end
      if (vld_b) begin
        if (qb.size() == 0) check("b_vld_unexpected", vld_b, 1'b0);
        else begin
          check("b_code", out_b, qb[0].code);
          check("b_idx",  idx_b, qb[0].idx);
          check("b_last", last_b, qb[0].last);
          check("b_err",  err_b, qb[0].err);
          if (!hold) void'(qb.pop_front());
        end
      end else begin
        check("b_idle_out", {err_b, last_b, out_b}, 7'd0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] w);
    re   = 1'b1;
    d_in = w;
    @(negedge clk);
    check("rdy_before_accept", rdy_a, 1'b1);
    push(w);
    cyc();
    re = 1'b0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; vcnt = 0; vraw = 0; mon_en = 1'b0;
    rs = 1'b1; re = 1'b1; hold = 1'b0; d_in = 16'h1234;
    cyc();
    mon_en = 1'b1;

    // Reset with RE asserted: nothing captured.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("t1_rdy_rst", rdy_a, 1'b0);
      check("t1_vld_rst", vld_a, 1'b0);
      check("t1_out_rst", out_a, 5'b00000);
      cyc();
    end
    rs = 1'b0; re = 1'b0;
    @(negedge clk);
    check("t1_rdy_after", rdy_a, 1'b1);
    repeat (3) cyc();
    check("t1_no_capture", vld_a, 1'b0);

    // Single word, MSD first.
    v0 = vcnt;
    send(16'h0159);
    repeat (5) cyc();
    check("t2_count", vcnt - v0, 4);
    check("t2_q_empty", qa.size(), 0);

    // Back-to-back words with RE held.
    v0 = vcnt;
    for (int k = 0; k < 9; k++) begin
      re   = (k < 8);
      d_in = (k < 4) ? 16'h2468 : 16'h7313;
      @(negedge clk);
      check("t3_rdy", rdy_a, (k == 0 || k == 4 || k == 8));
      if (k == 0) push(16'h2468);
      if (k == 4) push(16'h7313);
      cyc();
    end
    re = 1'b0;
    check("t3_contiguous", vcnt - v0, 8);
    @(negedge clk);
    check("t3_idle", vld_a, 1'b0);
    cyc();

    // HOLD for three edges while digit index 2 is shown.
    v0 = vcnt; r0 = vraw;
    send(16'h0159);
    d_in = 16'hFFFF;
    cyc();
    hold = 1'b1;
    repeat (3) cyc();
    hold = 1'b0;
    repeat (3) cyc();
    check("t4_raw_valid", vraw - r0, 7);
    check("t4_digits", vcnt - v0, 4);

    // Invalid digits on both wrap settings.
    send(16'h00AF);
    repeat (5) cyc();
    check("t5_qb_empty", qb.size(), 0);

    // Reset mid-word, then a fresh word.
    send(16'h5678);
    cyc();
    cyc();
    rs = 1'b1;
    @(negedge clk);
    check("t6_rdy_rst", rdy_a, 1'b0);
    cyc();
    rs = 1'b0;
    qa.delete();
    qb.delete();
    @(negedge clk);
    check("t6_vld_a_after_rst", vld_a, 1'b0);
    check("t6_vld_b_after_rst", vld_b, 1'b0);
    cyc();
    v0 = vcnt;
    send(16'h9999);
    repeat (5) cyc();
    check("t6_count", vcnt - v0, 4);

    check("end_qa_empty", qa.size(), 0);
    check("end_qb_empty", qb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/echo_codificador_serial.md
Name: echo_codificador_serial

Overview:
Multi-digit successor to the single-digit Johnson encoder. Accepts a word of N_DIG packed BCD digits through a ready/enable handshake. Converts each digit to the 5-bit Johnson (twisted-ring) display code. Emits the codes serially, one digit per cycle, with valid, last, index, error and hold/back-pressure support. Sits between the digit source (counter/keypad logic) and the Johnson-coded display driver.

Parameters:
N_DIG, 4, number of BCD digits per input word (>=1).
MSD_FIRST, 1, 1: emit most significant digit first; 0: least significant first.
WRAP_INVALID, 1, 1: digit values 10-15 are encoded as (value-10); 0: they are encoded as the illegal pattern 10101.
IDX_W, max(1,$clog2(N_DIG)), width of S_IDX (derived, do not override).

Ports:
CLK  in  1  clock. All logic is on the rising edge.
RS  in  1  synchronous active-high reset. Has priority over every other input.
RE  in  1  input enable: word offered on D_IN.
D_IN  in  4*N_DIG  packed digits. Digit i is D_IN[4i+3:4i]; digit 0 is least significant.
HOLD  in  1  downstream stall.
RDY  out  1  block can accept a word this cycle (combinational).
S_OUT  out  5  Johnson code {S1..S5} of the current digit (registered).
S_VLD  out  1  S_OUT valid (registered).
S_LAST  out  1  current digit is the last of the word (registered).
S_IDX  out  IDX_W  position i of the current digit within D_IN (registered).
ERR  out  1  current digit was >9 (registered).

Behaviour:
- Clock and reset: one clock, CLK. Reset RS is synchronous, active-high.
- Code table, value -> {S1..S5}:
  - 0 -> 11111, 1 -> 01111, 2 -> 00111, 3 -> 00011, 4 -> 00001
  - 5 -> 00000, 6 -> 10000, 7 -> 11000, 8 -> 11100, 9 -> 11110
- Values 10-15:
  - WRAP_INVALID=1: code of (value-10), ERR=1.
  - WRAP_INVALID=0: 10101, ERR=1.
- States: IDLE and SHIFT. The state is IDLE exactly when S_VLD=0.
- Reset (RS=1 at an edge):
  - State -> IDLE.
  - S_OUT=00000, S_VLD=0, S_LAST=0, S_IDX=0, ERR=0.
  - The latched word and digit counter are cleared.
  - RDY=0 combinationally while RS=1; RE is ignored.
  - Reset mid-word discards the remaining digits.
- RDY = ~RS & (IDLE | (S_VLD & S_LAST & ~HOLD)). Accept = RE & RDY.
- Accept edge:
  - Latch D_IN and enter SHIFT.
  - S_OUT/ERR/S_IDX are loaded with the first digit: index N_DIG-1 if MSD_FIRST, else 0.
  - S_VLD=1. S_LAST=1 when N_DIG=1.
  - Latency: the code is valid in the cycle after acceptance.
- SHIFT, edge with HOLD=0 and not last: advance to the next digit, one digit per cycle. S_LAST=1 on the final digit.
- SHIFT, edge with HOLD=0 on the last digit:
  - If Accept: load the new word as on an accept edge. There is no bubble; back-to-back words stream continuously.
  - Otherwise: go to IDLE, S_VLD=0, S_OUT=00000, S_LAST=0, ERR=0.
- HOLD=1 while S_VLD=1: all outputs and internal state are frozen. HOLD in IDLE has no effect.
- RE while RDY=0: ignored. The word is not captured and no flag is raised.
- D_IN is sampled only on the accept edge. Later changes have no effect on the word in flight.
- A word emits exactly N_DIG valid cycles, excluding HOLD cycles.

Test Plan:
1. RS=1 for 2 cycles with RE=1, D_IN=0x1234 -> RDY=0, S_VLD=0, S_OUT=00000 throughout. After RS drops, RDY=1 and no word was captured.
2. N_DIG=4, MSD_FIRST=1, one-cycle RE with D_IN=0x0159 -> next 4 cycles: S_OUT=11111, 01111, 00000, 11110; S_IDX=3, 2, 1, 0; S_LAST only on the 4th; ERR=0; then S_VLD=0.
3. RE held 1 with 0x2468, switched to 0x7313 on the first word's last cycle -> 8 contiguous valid cycles: 00111, 00001, 10000, 11100, 11000, 00011, 01111, 00011. RDY high only in IDLE and on each last cycle.
4. Word 0x0159 with HOLD=1 for 3 cycles while digit 1 is shown -> S_OUT=01111, S_IDX=2 frozen for 4 cycles total. Then 00000, 11110 follow; 7 valid cycles total.
5. D_IN=0x00AF with WRAP_INVALID=1 -> 11111, 11111, 11111(ERR=1), 00000(ERR=1). Same word with WRAP_INVALID=0 -> last two codes are 10101, ERR=1.
6. RS=1 for one cycle while digit index 1 is shown -> next cycle S_VLD=0. A new word 0x9999 then emits 11110 four times, starting at S_IDX=3.
